sec_counter_60: RTL and testbench
=================================

SEC_COUNTER_60 -- requirements
Module: sec_counter_60

Interface
REQ-001 Parameter CLK_DIV, default 100_000_000, clk cycles per count step; legal range 2 to 2^27.
REQ-002 clk  input  1  system clock; every register updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 btn  input  1  start/stop button level, already synchronous to clk; only its rising edge acts.
REQ-005 clr  input  1  synchronous clear, level-sensitive, active-high.
REQ-006 ones  output  4  units digit of seconds, binary 0-9.
REQ-007 tens  output  3  tens digit of seconds, binary 0-5; drives the tens seven-segment decoder directly.
REQ-008 carry  output  1  one-cycle pulse on wrap from 59 to 00; feeds the minutes stage.
REQ-009 running  output  1  high while in state RUN.

Function
REQ-010 The block SHALL register btn into btn_d each cycle, and btn_rise SHALL be btn & ~btn_d.
REQ-011 The FSM SHALL have three states: IDLE (stopped at 00), RUN, and PAUSE.
REQ-012 Transitions SHALL be: IDLE -btn_rise-> RUN; RUN -btn_rise-> PAUSE; PAUSE -btn_rise-> RUN.
REQ-013 If clr is high, the FSM SHALL go to IDLE from any state at the next edge, overriding btn_rise.
REQ-014 The 27-bit prescaler SHALL increment only in RUN, hold its value in PAUSE, and be 0 in IDLE.
REQ-015 tick SHALL be asserted when the prescaler equals CLK_DIV-1 in RUN; at that edge the prescaler SHALL return to 0.
REQ-016 On a tick edge, ones SHALL increment; at ones=9, ones SHALL go to 0 and tens SHALL increment.
REQ-017 At tens=5 and ones=9, a tick SHALL set both digits to 0 and assert carry for that one following cycle only.
REQ-018 carry SHALL be registered and SHALL coincide with the first cycle that shows 00.
REQ-019 In PAUSE, the digits SHALL hold; on resuming, the count SHALL continue from the held prescaler value, so partial seconds are kept.
REQ-020 clr SHALL zero ones, tens, the prescaler and carry at the next edge, overriding any tick in the same cycle.
REQ-021 tens SHALL never exceed 5 and ones SHALL never exceed 9; values 6/7 on tens and 10-15 on ones are unreachable.
REQ-022 If btn_rise arrives in the same cycle as a tick, RUN->PAUSE SHALL take effect and the tick SHALL still be counted.
REQ-023 Holding btn high SHALL produce exactly one transition; release and re-press SHALL be required for the next.
REQ-024 All outputs SHALL come directly from registers, with no combinational path from input to output.

Reset
REQ-025 While rst is high at an edge, the block SHALL set state to IDLE and set ones=0, tens=0, the prescaler to 0, carry=0, running=0 and btn_d=0.
REQ-026 rst SHALL override clr and btn.
REQ-027 rst asserted mid-count SHALL return the block to 00 IDLE at the next edge.
REQ-028 After rst deasserts, the block SHALL stay in IDLE until btn_rise.
REQ-029 If btn is high in the first cycle after reset, it SHALL count as a rising edge, because btn_d resets to 0.

Verification (CLK_DIV=4)
REQ-030 Reset, then btn pulse for 1 cycle -> running=1 next cycle; ones=1 after 4 more cycles; ones=9 after 36 cycles of running.
REQ-031 Run to 59 -> next tick gives tens=0, ones=0 and carry=1 for exactly 1 cycle, then carry=0.
REQ-032 Run 2 cycles into a second, pause for 20 cycles, resume -> digits unchanged during pause; next increment 2 cycles after resume.
REQ-033 clr and a tick in the same cycle at 37 -> next cycle 00, IDLE, running=0, carry=0.
REQ-034 btn held high for 50 cycles from IDLE -> a single transition to RUN, and counting continues throughout.
REQ-035 rst asserted at 45 in RUN with btn high -> 00 IDLE; after rst falls with btn still high -> RUN the next cycle.

Source files
------------

// File: rtl/sec_counter_60_if.sv
// -----------------------------------------------------------------------------
// sec_counter_60_if
// Bundles the control inputs and display/chain outputs of the seconds counter.
//   btn       : start/stop button level, synchronous to clk (master -> slave)
//   clr       : synchronous clear, active-high               (master -> slave)
//   ones      : seconds units digit, 0-9                     (slave -> master)
//   tens      : seconds tens digit, 0-5                      (slave -> master)
//   carry     : one-cycle pulse on 59 -> 00 wrap             (slave -> master)
//   running   : high while the counter is in RUN             (slave -> master)
//   state_dbg : raw FSM state for observation                (slave -> master)
// There is no valid/ready handshake: btn and clr are plain levels sampled on
// every rising clock edge, and every output is a registered level.
// -----------------------------------------------------------------------------
interface sec_counter_60_if;
    logic       btn;
    logic       clr;
    logic [3:0] ones;
    logic [2:0] tens;
    logic       carry;
    logic       running;
    logic [1:0] state_dbg;

    modport master (
        output btn,
        output clr,
        input  ones,
        input  tens,
        input  carry,
        input  running,
        input  state_dbg
    );

    modport slave (
        input  btn,
        input  clr,
        output ones,
        output tens,
        output carry,
        output running,
        output state_dbg
    );
endinterface

// File: rtl/sec_counter_60.sv
// -----------------------------------------------------------------------------
// sec_counter_60
// Start/stop/pause seconds counter (00-59) with a CLK_DIV prescaler.
//   CLK_DIV : clk cycles per one-second step (2 .. 2^27)
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset, overrides everything
//   bus     : sec_counter_60_if.slave (btn, clr in; ones, tens, carry,
//             running, state_dbg out)
// A rising edge of btn cycles IDLE -> RUN -> PAUSE -> RUN ...; clr returns to
// IDLE at 00. All outputs come straight from flops.
// -----------------------------------------------------------------------------
module sec_counter_60 #(
    parameter int unsigned CLK_DIV = 100_000_000
) (
    input  logic            clk,
    input  logic            rst,
    sec_counter_60_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [26:0] PRESC_LAST = 27'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic        btn_d_q, btn_d_d;
    logic [26:0] presc_q, presc_d;
    logic [3:0]  ones_q, ones_d;
    logic [2:0]  tens_q, tens_d;
    logic        carry_q, carry_d;
    logic        running_q, running_d;

    logic btn_rise;
    logic tick;

    // btn_d_q holds last cycle's btn; it resets to 0 so a btn already high
    // right after reset still counts as a press.
    assign btn_d_d  = bus.btn;
    assign btn_rise = bus.btn & ~btn_d_q;
    assign tick     = (state_q == RUN) && (presc_q == PRESC_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (bus.clr) begin
            state_d = IDLE;
        end else if (btn_rise) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // running is decoded from the next state so it can be registered and
    // still line up with state_q.
    always_comb begin
        running_d = (state_d == RUN);
    end

    // ---------------- Datapath next values ----------------
    // A tick is evaluated on the current state, so a press that moves RUN to
    // PAUSE in the same cycle still counts the second that just elapsed.
    always_comb begin
        presc_d = presc_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        carry_d = 1'b0;
        if (bus.clr) begin
            presc_d = '0;
            ones_d  = '0;
            tens_d  = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (tick) begin
                        presc_d = '0;
                        if (ones_q == 4'd9) begin
                            ones_d = 4'd0;
                            if (tens_q == 3'd5) begin
                                tens_d  = 3'd0;
                                carry_d = 1'b1;
                            end else begin
                                tens_d = tens_q + 3'd1;
                            end
                        end else begin
                            ones_d = ones_q + 4'd1;
                        end
                    end else begin
                        presc_d = presc_q + 27'd1;
                    end
                end
                PAUSE: begin
                    // Partial second and digits are held.
                    presc_d = presc_q;
                end
                default: begin
                    presc_d = '0;
                end
            endcase
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_d_q   <= 1'b0;
            presc_q   <= '0;
            ones_q    <= '0;
            tens_q    <= '0;
            carry_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            btn_d_q   <= btn_d_d;
            presc_q   <= presc_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            carry_q   <= carry_d;
            running_q <= running_d;
        end
    end

    assign bus.ones      = ones_q;
    assign bus.tens      = tens_q;
    assign bus.carry     = carry_q;
    assign bus.running   = running_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_sec_counter_60.sv
// -----------------------------------------------------------------------------
// tb_sec_counter_60
// Directed bench for sec_counter_60 with CLK_DIV = 4. A seconds-level model
// (mode, phase within the second, elapsed seconds 0-59) predicts the outputs
// every cycle; directed literal checks pin key points of the scenarios.
// -----------------------------------------------------------------------------
module tb_sec_counter_60;
  localparam int CLK_DIV = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  typedef struct {
    int mode;
    int phase;
    int secs;
    bit carry;
    bit prev_btn;
  } model_t;

  logic clk;
  logic rst;
  sec_counter_60_if bus();

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];
  model_t m;

  sec_counter_60 #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic model_t model_step(model_t s, bit r, bit b, bit c);
    model_t n;
    bit rise;
    bit tick;
    n = s;
    if (r) begin
      n.mode = M_IDLE; n.phase = 0; n.secs = 0; n.carry = 1'b0; n.prev_btn = 1'b0;
      return n;
    end
    rise = b && !s.prev_btn;
    tick = (s.mode == M_RUN) && (s.phase == CLK_DIV - 1);
    n.carry = 1'b0;
    n.prev_btn = b;
    if (c) begin
      n.mode = M_IDLE; n.phase = 0; n.secs = 0;
    end else begin
      if (s.mode == M_RUN) begin
        if (tick) begin
          n.phase = 0;
          n.secs  = (s.secs + 1) % 60;
          n.carry = (s.secs == 59);
        end else begin
          n.phase = s.phase + 1;
        end
      end
      if (rise) n.mode = (s.mode == M_RUN) ? M_PAUSE : M_RUN;
    end
    return n;
  endfunction

  function automatic logic [8:0] model_outs(model_t s);
    logic [3:0] o;
    logic [2:0] t;
    o = 4'(s.secs % 10);
    t = 3'(s.secs / 10);
    return {(s.mode == M_RUN), s.carry, t, o};
  endfunction

  always @(posedge clk) begin
    exp_q.push_back(model_outs(model_step(m, rst, bus.btn, bus.clr)));
    m <= model_step(m, rst, bus.btn, bus.clr);
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      chk("scoreboard {running,carry,tens,ones}",
          int'({bus.running, bus.carry, bus.tens, bus.ones}),
          int'(exp_q.pop_front()));
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_out(input string name, input int ones, input int tens,
                         input int running, input int carry);
    chk({name, " ones"}, int'(bus.ones), ones);
    chk({name, " tens"}, int'(bus.tens), tens);
    chk({name, " running"}, int'(bus.running), running);
    chk({name, " carry"}, int'(bus.carry), carry);
  endtask

  initial begin
    rst = 1'b1;
    bus.btn = 1'b0;
    bus.clr = 1'b0;
    step(3);
    chk_out("reset", 0, 0, 0, 0);
    rst = 1'b0;
    step(2);
    chk_out("idle after reset", 0, 0, 0, 0);

    // Start with a one-cycle press.
    bus.btn = 1'b1;
    step(1);
    chk_out("start", 0, 0, 1, 0);
    bus.btn = 1'b0;
    step(3);
    chk("pre first tick ones", int'(bus.ones), 0);
    step(1);
    chk("first tick ones", int'(bus.ones), 1);
    step(32);
    chk_out("36 cycles running", 9, 0, 1, 0);

    // Run to 59 and wrap.
    step(200);
    chk_out("at 59", 9, 5, 1, 0);
    step(4);
    chk_out("wrap", 0, 0, 1, 1);
    step(1);
    chk_out("after wrap", 0, 0, 1, 0);

    // Pause two cycles into a second, hold, resume.
    bus.btn = 1'b1;
    step(1);
    bus.btn = 1'b0;
    chk_out("paused", 0, 0, 0, 0);
    step(20);
    chk_out("still paused", 0, 0, 0, 0);
    bus.btn = 1'b1;
    step(1);
    bus.btn = 1'b0;
    chk_out("resumed", 0, 0, 1, 0);
    step(1);
    chk("resume +1 ones", int'(bus.ones), 0);
    step(1);
    chk("resume +2 ones", int'(bus.ones), 1);

    // Reach 37, then clear exactly on a tick cycle.
    step(144);
    chk_out("at 37", 7, 3, 1, 0);
    step(3);
    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
    chk_out("clr over tick", 0, 0, 0, 0);

    // Held button: one transition only.
    bus.btn = 1'b1;
    step(50);
    chk_out("btn held 50", 2, 1, 1, 0);
    bus.btn = 1'b0;

    // Reach 45, reset with btn high, release reset with btn still high.
    step(131);
    chk_out("at 45", 5, 4, 1, 0);
    bus.btn = 1'b1;
    rst = 1'b1;
    bus.clr = 1'b1;
    step(1);
    chk_out("rst mid count", 0, 0, 0, 0);
    rst = 1'b0;
    bus.clr = 1'b0;
    step(1);
    chk_out("btn high after rst", 0, 0, 1, 0);
    step(8);
    bus.btn = 1'b0;
    chk("after rst two ticks ones", int'(bus.ones), 2);
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
